ad_capture_ctrl: RTL and testbench
==================================

AD_CAPTURE_CTRL -- requirements
Module: ad_capture_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 8, clk-to-ad_clk divide ratio (even, 4..16).
REQ-002 SHALL have parameter DEPTH, default 256, capture buffer words (power of two).
REQ-003 SHALL have parameter PIPE_LAT, default 3, ADC pipeline samples discarded after arming.
REQ-004 SHALL have port clk  in  1  system clock; single clock domain.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ad_data  in  8  ADC parallel output.
REQ-007 SHALL have port ad_otr  in  1  ADC over-range flag.
REQ-008 SHALL have port ad_clk  out  1  ADC conversion clock.
REQ-009 SHALL have port start  in  1  one-cycle arm request.
REQ-010 SHALL have port trig_mode  in  1  0 = rising-level trigger, 1 = immediate.
REQ-011 SHALL have port trig_level  in  8  trigger threshold, sampled at arm.
REQ-012 SHALL have port busy  out  1  high in FLUSH/ARM/CAPTURE.
REQ-013 SHALL have port done  out  1  level, high in DONE.
REQ-014 SHALL have port otr_seen  out  1  sticky: any ad_otr during CAPTURE.
REQ-015 SHALL have port rd_addr  in  log2(DEPTH)  buffer read address.
REQ-016 SHALL have port rd_data  out  8  buffer read data.

Function
REQ-017 SHALL run divider counter cnt 0..DIV/2-1 continuously; at cnt==DIV/2-1, cnt wraps to 0 and ad_clk toggles (ad_clk period = DIV clk cycles, 50% duty).
REQ-018 SHALL generate internal sample strobe in the cycle where cnt==DIV/2-1 and ad_clk==1 (ad_clk falling edge); ad_data registered only on strobe.
REQ-019 SHALL implement states IDLE, FLUSH, ARM, CAPTURE, DONE.
REQ-020 IDLE/DONE + start -> FLUSH; start latches trig_mode, trig_level; done, otr_seen cleared same cycle.
REQ-021 start in FLUSH/ARM/CAPTURE SHALL be ignored.
REQ-022 FLUSH SHALL discard exactly PIPE_LAT strobes, then -> ARM (trig_mode 0) or CAPTURE (trig_mode 1).
REQ-023 ARM SHALL hold previous sample prev; trigger when prev < trig_level and current >= trig_level; first strobe in ARM only loads prev.
REQ-024 Triggering sample SHALL be written at address 0; state -> CAPTURE.
REQ-025 CAPTURE SHALL write each strobed sample at incrementing write address; after address DEPTH-1 written -> DONE next cycle; no wrap, no overwrite.
REQ-026 Immediate mode: first CAPTURE strobe writes address 0.
REQ-027 otr_seen SHALL set on any strobe in CAPTURE (incl. trigger sample) with ad_otr==1; held until next accepted start.
REQ-028 rd_data SHALL be registered, valid 1 clk after rd_addr; reads allowed in any state; write/read same address same cycle returns old data.
REQ-029 ARM SHALL wait indefinitely; no timeout.
REQ-030 threshold 0 SHALL never trigger (prev < 0 impossible); threshold at constant input level SHALL not trigger.

Reset
REQ-031 rst_n low SHALL force, asynchronously: ad_clk=0, cnt=0, state IDLE, busy=0, done=0, otr_seen=0, rd_data=0, write address 0.
REQ-032 Reset mid-capture SHALL abort; buffer contents undefined; requires new start.
REQ-033 After rst_n release, ad_clk first rises DIV/2 clk cycles later.

Verification
REQ-034 DIV=8, reset release -> ad_clk period 8 clk, high 4, first rise at cycle 4; strobe every 8 clk.
REQ-035 trig_mode 1, ad_data ramp 0,1,2,...per strobe, start -> first 3 ramp values discarded, buffer[0..255]=3..258 mod 256, done after 256+3 strobes.
REQ-036 trig_mode 0, level 0x80, ad_data sequence 0x10,0x7F,0x80,0x90 after flush -> buffer[0]=0x80, buffer[1]=0x90.
REQ-037 constant ad_data=0xA0, level 0x80, trig_mode 0 -> stays ARM, busy=1, done=0 indefinitely.
REQ-038 ad_otr pulsed during one CAPTURE strobe -> otr_seen=1 until next start; start while busy -> no state change.
REQ-039 rst_n asserted at sample 100 of CAPTURE -> all outputs to reset values immediately; new start restarts from FLUSH.

Source files
------------

// File: rtl/ad_capture_ctrl.sv
// ad_capture_ctrl: drives an 8-bit pipelined ADC and captures one buffer of samples.
// The ADC clock is derived from clk. Samples are taken on the ad_clk falling edge.
// After a start request the controller flushes the ADC pipeline samples. It then either
// waits for a rising crossing of trig_level or begins capturing at once. It fills
// DEPTH words of internal RAM and holds done until the next start.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ad_data, ad_otr     ADC parallel output and over-range flag
//   ad_clk              ADC conversion clock (DIV clk cycles per period)
//   start               one-cycle arm request (accepted in IDLE/DONE only)
//   trig_mode           0 = rising-level trigger, 1 = immediate capture
//   trig_level          trigger threshold, latched on an accepted start
//   busy, done          status levels (busy in FLUSH/ARM/CAPTURE, done in DONE)
//   otr_seen            sticky over-range flag for the current capture
//   rd_addr, rd_data    buffer read port, data valid one clk after address
module ad_capture_ctrl #(
  parameter int unsigned DIV      = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned PIPE_LAT = 3    // must be >= 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 ad_data,
  input  logic                       ad_otr,
  output logic                       ad_clk,
  input  logic                       start,
  input  logic                       trig_mode,
  input  logic [7:0]                 trig_level,
  output logic                       busy,
  output logic                       done,
  output logic                       otr_seen,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [7:0]                 rd_data
);

  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(HALF);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned FW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    ARM     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] flush_cnt;
  logic [AW-1:0] waddr;
  logic [7:0]    samp_q;
  logic          prev_vld;
  logic          mode_q;
  logic [7:0]    level_q;
  logic [7:0]    mem [DEPTH];

  logic          strobe;
  logic          trig_hit;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  // ad_clk divider: toggles each time cnt wraps, giving a DIV-cycle period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      ad_clk <= 1'b0;
    end else if (cnt == CW'(HALF - 1)) begin
      cnt    <= '0;
      ad_clk <= ~ad_clk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Sample strobe marks the clk edge on which ad_clk falls
  assign strobe = (cnt == CW'(HALF - 1)) && ad_clk;

  // samp_q holds the previous strobed sample; it is the trigger comparator's "prev"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp_q <= 8'd0;
    else if (strobe) samp_q <= ad_data;
  end

  // Strict prev < level excludes a constant input and makes level 0 unreachable
  assign trig_hit = (samp_q < level_q) && (ad_data >= level_q);

  assign wr_en   = strobe && ((state == CAPTURE) || ((state == ARM) && prev_vld && trig_hit));
  assign wr_addr = (state == ARM) ? '0 : waddr;

  // Capture sequencer with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      waddr     <= '0;
      prev_vld  <= 1'b0;
      mode_q    <= 1'b0;
      level_q   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      otr_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q    <= trig_mode;
            level_q   <= trig_level;
            flush_cnt <= '0;
            waddr     <= '0;
            prev_vld  <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            otr_seen  <= 1'b0;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (strobe) begin
            if (flush_cnt == FW'(PIPE_LAT - 1)) begin
              state <= mode_q ? CAPTURE : ARM;
            end else begin
              flush_cnt <= flush_cnt + FW'(1);
            end
          end
        end
        ARM: begin
          if (strobe) begin
            prev_vld <= 1'b1;
            if (prev_vld && trig_hit) begin
              // Trigger sample lands at address 0; capture resumes at 1
              waddr <= AW'(1);
              state <= CAPTURE;
              if (ad_otr) otr_seen <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (strobe) begin
            if (ad_otr) otr_seen <= 1'b1;
            if (waddr == AW'(DEPTH - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              waddr <= waddr + AW'(1);
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Capture RAM write port (no reset: contents are don't-care until written)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= ad_data;
  end

  // Registered read port; a same-address write in the same cycle returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'd0;
    else rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Directed testbench for ad_capture_ctrl with default parameters (DIV=8, DEPTH=256, PIPE_LAT=3).
// It checks reset values, ad_clk timing, immediate ramp capture, level triggering, over-range
// stickiness, ignored start while busy, a non-triggering constant input, and asynchronous abort.
module tb_ad_capture_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] ad_data;
  logic       ad_otr;
  logic       ad_clk;
  logic       start;
  logic       trig_mode;
  logic [7:0] trig_level;
  logic       busy;
  logic       done;
  logic       otr_seen;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  int vectors = 0;
  int miscompares = 0;

  ad_capture_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ad_data    (ad_data),
    .ad_otr     (ad_otr),
    .ad_clk     (ad_clk),
    .start      (start),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .busy       (busy),
    .done       (done),
    .otr_seen   (otr_seen),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next ad_clk falling edge (the sample strobe), bounded
  task automatic wait_strobe();
    logic p;
    bit   got;
    got = 1'b0;
    p   = ad_clk;
    for (int i = 0; i < 18 && !got; i++) begin
      tick();
      if (p && !ad_clk) got = 1'b1;
      p = ad_clk;
    end
    if (!got) chk("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Level-trigger stimulus: 3 flushed samples, then 0x10,0x7F,0x80,0x90, then a ramp
  function automatic logic [7:0] lvl_val(input int s);
    case (s)
      1: return 8'h40;
      2: return 8'h20;
      3: return 8'h00;
      4: return 8'h10;
      5: return 8'h7F;
      6: return 8'h80;
      default: return 8'(144 + s - 7);
    endcase
  endfunction

  // Immediate-mode ramp capture of a full buffer; expects done exactly after 259 strobes
  task automatic ramp_run(input string tag, input bit poke_start);
    trig_mode  = 1'b1;
    trig_level = 8'h00;
    ad_data    = 8'd0;
    pulse_start();
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_start"}, 32'(done), 32'd0);
    for (int s = 1; s <= 259; s++) begin
      wait_strobe();
      ad_data = ad_data + 8'd1;
      if (poke_start && s == 100) begin
        trig_mode = 1'b0;
        pulse_start();
        trig_mode = 1'b1;
      end
      if (s == 258) begin
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        chk({tag, "_busy_258"}, 32'(busy), 32'd1);
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_otr"}, 32'(otr_seen), 32'd0);
    rd_chk({tag, "_buf0"}, 8'd0, 8'd3);
    rd_chk({tag, "_buf1"}, 8'd1, 8'd4);
    rd_chk({tag, "_buf253"}, 8'd253, 8'd0);
    rd_chk({tag, "_buf255"}, 8'd255, 8'd2);
  endtask

  initial begin
    rst_n      = 1'b0;
    ad_data    = 8'd0;
    ad_otr     = 1'b0;
    start      = 1'b0;
    trig_mode  = 1'b0;
    trig_level = 8'd0;
    rd_addr    = 8'd0;

    // Reset values
    #2;
    chk("rst_ad_clk", 32'(ad_clk), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_otr", 32'(otr_seen), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // ad_clk: first rise 4 clk after release, period 8
    repeat (3) tick();
    chk("adclk_t3", 32'(ad_clk), 32'd0);
    tick();
    chk("adclk_t4", 32'(ad_clk), 32'd1);
    repeat (3) tick();
    chk("adclk_t7", 32'(ad_clk), 32'd1);
    tick();
    chk("adclk_t8", 32'(ad_clk), 32'd0);
    repeat (4) tick();
    chk("adclk_t12", 32'(ad_clk), 32'd1);
    repeat (4) tick();
    chk("adclk_t16", 32'(ad_clk), 32'd0);

    // Immediate ramp capture, with a start pulse while busy that must be ignored
    ramp_run("ramp", 1'b1);

    // Level trigger at 0x80 with one over-range sample during capture
    trig_mode  = 1'b0;
    trig_level = 8'h80;
    ad_data    = lvl_val(1);
    pulse_start();
    for (int s = 1; s <= 261; s++) begin
      wait_strobe();
      ad_data = lvl_val(s + 1);
      ad_otr  = (s + 1 == 11);
      if (s == 5) begin
        chk("lvl_busy_arm", 32'(busy), 32'd1);
        chk("lvl_done_arm", 32'(done), 32'd0);
      end
      if (s == 10) chk("lvl_otr_before", 32'(otr_seen), 32'd0);
      if (s == 11) chk("lvl_otr_after", 32'(otr_seen), 32'd1);
      if (s == 260) chk("lvl_done_early", 32'(done), 32'd0);
    end
    chk("lvl_done", 32'(done), 32'd1);
    chk("lvl_otr_held", 32'(otr_seen), 32'd1);
    rd_chk("lvl_buf0", 8'd0, 8'h80);
    rd_chk("lvl_buf1", 8'd1, 8'h90);
    rd_chk("lvl_buf2", 8'd2, 8'h91);
    rd_chk("lvl_buf255", 8'd255, 8'h8E);

    // Constant input above level never triggers; new start clears done/otr_seen
    ad_data = 8'hA0;
    pulse_start();
    chk("const_otr_cleared", 32'(otr_seen), 32'd0);
    chk("const_done_cleared", 32'(done), 32'd0);
    for (int s = 1; s <= 40; s++) begin
      wait_strobe();
      if (s == 20) pulse_start();
    end
    chk("const_busy", 32'(busy), 32'd1);
    chk("const_done", 32'(done), 32'd0);

    // Leave the stuck ARM state
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Immediate capture aborted by reset at capture sample 100
    trig_mode = 1'b1;
    ad_data   = 8'd0;
    rd_addr   = 8'd0;
    pulse_start();
    for (int s = 1; s <= 103; s++) begin
      wait_strobe();
      ad_data = ad_data + 8'd1;
      ad_otr  = (s + 1 == 53);
    end
    repeat (4) tick();
    chk("abort_adclk_high", 32'(ad_clk), 32'd1);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    chk("abort_otr_pre", 32'(otr_seen), 32'd1);
    chk("abort_rd_pre", 32'(rd_data), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ad_clk", 32'(ad_clk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_otr", 32'(otr_seen), 32'd0);
    chk("abort_rd_data", 32'(rd_data), 32'd0);
    tick();
    rst_n = 1'b1;

    // Fresh start after the abort runs the full flush + capture again
    ramp_run("restart", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
